// File: rtl/moxie_pkg.sv
// Shared definitions for the Moxie fetch/decode/execute pipeline:
// opcode values, internal op encoding, fetch states and stage payloads.
package moxie_pkg;

   localparam int REG_IDX_W = 4;

   localparam logic [7:0] OPC_LDI = 8'h01;
   localparam logic [7:0] OPC_MOV = 8'h02;
   localparam logic [7:0] OPC_ADD = 8'h05;
   localparam logic [7:0] OPC_NOP = 8'h0f;
   localparam logic [7:0] OPC_AND = 8'h26;
   localparam logic [7:0] OPC_SUB = 8'h29;
   localparam logic [7:0] OPC_NEG = 8'h2a;
   localparam logic [7:0] OPC_OR  = 8'h2b;
   localparam logic [7:0] OPC_NOT = 8'h2c;
   localparam logic [7:0] OPC_XOR = 8'h2e;

   typedef enum logic [5:0] {
      OP_NONE = 6'd0,
      OP_LDI  = 6'd1,
      OP_MOV  = 6'd2,
      OP_ADD  = 6'd3,
      OP_SUB  = 6'd4,
      OP_AND  = 6'd5,
      OP_OR   = 6'd6,
      OP_XOR  = 6'd7,
      OP_NOT  = 6'd8,
      OP_NEG  = 6'd9
   } op_e;

   typedef enum logic [0:0] {
      ST_FETCH   = 1'b0,
      ST_OPERAND = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic        valid;
      logic [15:0] opcode;
      logic [31:0] operand;
   } fetch_out_t;

   typedef struct packed {
      op_e                  op;
      logic                 read_a;
      logic                 read_b;
      logic                 write_en;
      logic [REG_IDX_W-1:0] idx_a;
      logic [REG_IDX_W-1:0] idx_b;
      logic [31:0]          operand;
   } decode_out_t;

   function automatic op_e map_op(input logic [7:0] opc);
      case (opc)
         OPC_LDI: map_op = OP_LDI;
         OPC_MOV: map_op = OP_MOV;
         OPC_ADD: map_op = OP_ADD;
         OPC_SUB: map_op = OP_SUB;
         OPC_AND: map_op = OP_AND;
         OPC_OR:  map_op = OP_OR;
         OPC_XOR: map_op = OP_XOR;
         OPC_NOT: map_op = OP_NOT;
         OPC_NEG: map_op = OP_NEG;
         OPC_NOP: map_op = OP_NONE;
         default: map_op = OP_NONE;
      endcase
   endfunction

endpackage

// File: rtl/cpu_decode.sv
// Decode stage: turns a fetched opcode into register-file read/write
// controls; holds its contents while a hazard stall is in progress.
module cpu_decode
   import moxie_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  fetch_out_t  fetch_i,
   output decode_out_t dec_o
);

   decode_out_t dec_q, dec_d;
   op_e         op;

   assign op = map_op(fetch_i.opcode[15:8]);

   always_comb begin
      dec_d = '0;
      if (stall_i) begin
         dec_d = dec_q;
      end else if (fetch_i.valid) begin
         dec_d.op      = op;
         dec_d.idx_a   = fetch_i.opcode[7:4];
         dec_d.idx_b   = fetch_i.opcode[3:0];
         dec_d.operand = fetch_i.operand;
         case (op)
            OP_LDI: dec_d.write_en = 1'b1;
            OP_MOV, OP_NOT, OP_NEG: begin
               dec_d.read_b   = 1'b1;
               dec_d.write_en = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
               dec_d.read_a   = 1'b1;
               dec_d.read_b   = 1'b1;
               dec_d.write_en = 1'b1;
            end
            default: dec_d.write_en = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) dec_q <= '0;
      else       dec_q <= dec_d;
   end

   assign dec_o = dec_q;

endmodule

// File: rtl/cpu_execute.sv
// Execute stage: computes the 32-bit result and registers the
// register-file write port.
module cpu_execute
   import moxie_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  op_e                  op_i,
   input  logic                 write_en_i,
   input  logic [REG_IDX_W-1:0] write_index_i,
   input  logic [31:0]          operand_i,
   input  logic [31:0]          value1_i,
   input  logic [31:0]          value2_i,
   output logic                 write_enable_o,
   output logic [REG_IDX_W-1:0] write_index_o,
   output logic [31:0]          write_data_o
);

   logic                 we_q;
   logic [REG_IDX_W-1:0] idx_q;
   logic [31:0]          data_q, data_d;

   always_comb begin
      data_d = '0;
      case (op_i)
         OP_LDI:  data_d = operand_i;
         OP_MOV:  data_d = value2_i;
         OP_ADD:  data_d = value1_i + value2_i;
         OP_SUB:  data_d = value1_i - value2_i;
         OP_AND:  data_d = value1_i & value2_i;
         OP_OR:   data_d = value1_i | value2_i;
         OP_XOR:  data_d = value1_i ^ value2_i;
         OP_NOT:  data_d = ~value2_i;
         OP_NEG:  data_d = 32'd0 - value2_i;
         default: data_d = '0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         we_q   <= 1'b0;
         idx_q  <= '0;
         data_q <= '0;
      end else begin
         we_q   <= write_en_i;
         idx_q  <= write_index_i;
         data_q <= data_d;
      end
   end

   assign write_enable_o = we_q;
   assign write_index_o  = idx_q;
   assign write_data_o   = data_q;

endmodule

// File: rtl/cpu_fetch.sv
// Fetch stage: walks the instruction stream and pairs ldi.l opcodes with
// their trailing immediate word before handing them to decode.
module cpu_fetch
   import moxie_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic [31:0] imem_data_i,
   output logic [31:0] imem_address_o,
   output fetch_out_t  fetch_o
);

   fetch_state_e state_q, state_d;
   logic [31:0]  addr_q, addr_d;
   logic [15:0]  held_q, held_d;
   fetch_out_t   out_q, out_d;
   logic [15:0]  opcode;

   assign opcode = imem_data_i[31:16];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_FETCH;
         addr_q  <= RESET_PC;
         held_q  <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         held_q  <= held_d;
         out_q   <= out_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!stall_i) begin
         case (state_q)
            ST_FETCH:   if (opcode[15:8] == OPC_LDI) state_d = ST_OPERAND;
            ST_OPERAND: state_d = ST_FETCH;
            default:    state_d = ST_FETCH;
         endcase
      end
   end

   // The ldi.l opcode cycle emits a bubble; the immediate cycle emits the pair.
   always_comb begin
      addr_d = addr_q;
      held_d = held_q;
      out_d  = out_q;
      if (!stall_i) begin
         addr_d = addr_q + 32'd4;
         case (state_q)
            ST_FETCH: begin
               if (opcode[15:8] == OPC_LDI) begin
                  held_d = opcode;
                  out_d  = '0;
               end else begin
                  out_d = {1'b1, opcode, 32'd0};
               end
            end
            ST_OPERAND: out_d = {1'b1, held_q, imem_data_i};
            default:    out_d = '0;
         endcase
      end
   end

   assign imem_address_o = addr_q;
   assign fetch_o        = out_q;

endmodule

// File: rtl/moxie_fde_pipeline.sv
// Moxie fetch/decode/execute pipeline with a one-cycle read-after-write
// stall against the instruction currently in writeback.
module moxie_fde_pipeline
   import moxie_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [31:0]          imem_data_i,
   output logic [31:0]          imem_address_o,
   output logic [REG_IDX_W-1:0] rf_read_index1_o,
   output logic [REG_IDX_W-1:0] rf_read_index2_o,
   output logic                 rf_read_enable_o,
   input  logic [31:0]          rf_value1_i,
   input  logic [31:0]          rf_value2_i,
   output logic                 rf_write_enable_o,
   output logic [REG_IDX_W-1:0] rf_write_index_o,
   output logic [31:0]          rf_write_data_o,
   output logic                 stall_o
);

   fetch_out_t  fetch;
   decode_out_t dec;
   logic        stall;

   // The register file only sees the pending write on the next edge, so a
   // reader of that register waits one cycle while execute inserts a bubble.
   assign stall = (dec.read_a & rf_write_enable_o & (dec.idx_a == rf_write_index_o))
                | (dec.read_b & rf_write_enable_o & (dec.idx_b == rf_write_index_o));

   cpu_fetch #(.RESET_PC(RESET_PC)) u_fetch (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .stall_i        (stall),
      .imem_data_i    (imem_data_i),
      .imem_address_o (imem_address_o),
      .fetch_o        (fetch)
   );

   cpu_decode u_decode (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .stall_i (stall),
      .fetch_i (fetch),
      .dec_o   (dec)
   );

   cpu_execute u_execute (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .op_i           (dec.op),
      .write_en_i     (dec.write_en & ~stall),
      .write_index_i  (dec.idx_a),
      .operand_i      (dec.operand),
      .value1_i       (rf_value1_i),
      .value2_i       (rf_value2_i),
      .write_enable_o (rf_write_enable_o),
      .write_index_o  (rf_write_index_o),
      .write_data_o   (rf_write_data_o)
   );

   assign rf_read_index1_o = dec.idx_a;
   assign rf_read_index2_o = dec.idx_b;
   assign rf_read_enable_o = dec.read_a | dec.read_b;
   assign stall_o          = stall;

endmodule

// File: tb/tb_moxie_fde_pipeline.sv
// Directed bench: instruction memory and register file models around the
// pipeline, with a scoreboard of expected register writes and their cycles.
module tb_moxie_fde_pipeline;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [31:0] imem_data_i;
   logic [31:0] imem_address_o;
   logic [3:0]  rf_read_index1_o, rf_read_index2_o;
   logic        rf_read_enable_o;
   logic [31:0] rf_value1_i, rf_value2_i;
   logic        rf_write_enable_o;
   logic [3:0]  rf_write_index_o;
   logic [31:0] rf_write_data_o;
   logic        stall_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0]  idx;
      logic [31:0] data;
      int          cyc;
   } wr_t;
   wr_t sb[$];

   logic [31:0] imem [0:63];
   logic [31:0] rf   [0:15];

   always #5 clk_i = ~clk_i;

   assign imem_data_i = imem[imem_address_o[7:2]];
   assign rf_value1_i = rf[rf_read_index1_o];
   assign rf_value2_i = rf[rf_read_index2_o];

   always @(posedge clk_i)
      if (rf_write_enable_o) rf[rf_write_index_o] <= rf_write_data_o;

   moxie_fde_pipeline #(.RESET_PC(32'h0000_0000)) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .imem_data_i       (imem_data_i),
      .imem_address_o    (imem_address_o),
      .rf_read_index1_o  (rf_read_index1_o),
      .rf_read_index2_o  (rf_read_index2_o),
      .rf_read_enable_o  (rf_read_enable_o),
      .rf_value1_i       (rf_value1_i),
      .rf_value2_i       (rf_value2_i),
      .rf_write_enable_o (rf_write_enable_o),
      .rf_write_index_o  (rf_write_index_o),
      .rf_write_data_o   (rf_write_data_o),
      .stall_o           (stall_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 64; i++) imem[i] = 32'h0F00_0000;
   endtask

   task automatic expect_wr(input logic [3:0] idx, input logic [31:0] data, input int cyc);
      wr_t w;
      w.idx  = idx;
      w.data = data;
      w.cyc  = cyc;
      sb.push_back(w);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   // Cycle k is the one following the k-th rising edge after reset release.
   task automatic run(input string tag, input int n, input int stall_at);
      logic [31:0] exp_addr;
      wr_t         w;
      exp_addr = 32'h0;
      for (int k = 0; k < n; k++) begin
         if (k > 0) @(negedge clk_i);
         #1;
         chk($sformatf("%s addr k=%0d", tag, k), imem_address_o, exp_addr);
         chk($sformatf("%s stall k=%0d", tag, k), {31'd0, stall_o}, {31'd0, k == stall_at});
         if (rf_write_enable_o === 1'b1) begin
            $display("[%s] k=%0d write r%0d = %h", tag, k, rf_write_index_o, rf_write_data_o);
            chk($sformatf("%s write expected k=%0d", tag, k), {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
               w = sb.pop_front();
               chk($sformatf("%s widx k=%0d", tag, k), {28'd0, rf_write_index_o}, {28'd0, w.idx});
               chk($sformatf("%s wdata k=%0d", tag, k), rf_write_data_o, w.data);
               chk($sformatf("%s wcycle", tag), k, w.cyc);
            end
         end
         if (k != stall_at) exp_addr = exp_addr + 32'd4;
      end
      chk($sformatf("%s writes outstanding", tag), sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      // Reset state while reset is held from time zero
      clear_imem();
      #3;
      chk("reset addr", imem_address_o, 32'h0);
      chk("reset we", {31'd0, rf_write_enable_o}, 32'd0);
      chk("reset stall", {31'd0, stall_o}, 32'd0);

      // ldi.l $r1, 5
      imem[0] = 32'h0110_0000; imem[1] = 32'h0000_0005;
      expect_wr(4'd1, 32'h5, 4);
      do_reset();
      run("ldi", 8, -1);

      // RAW hazard: add reads r2 while its ldi write is pending
      clear_imem();
      imem[0] = 32'h0110_0000; imem[1] = 32'h0000_0005;
      imem[2] = 32'h0120_0000; imem[3] = 32'h0000_0007;
      imem[4] = 32'h0512_0000;
      expect_wr(4'd1, 32'h5, 4);
      expect_wr(4'd2, 32'h7, 6);
      expect_wr(4'd1, 32'hC, 8);
      do_reset();
      run("raw", 11, 6);

      // Wrap-around arithmetic, nops keep dependent ops apart
      clear_imem();
      imem[0] = 32'h0110_0000; imem[1] = 32'hFFFF_FFFF;
      imem[2] = 32'h0120_0000; imem[3] = 32'h0000_0001;
      imem[5] = 32'h0512_0000;
      imem[7] = 32'h2912_0000;
      imem[9] = 32'h2A32_0000;
      expect_wr(4'd1, 32'hFFFF_FFFF, 4);
      expect_wr(4'd2, 32'h0000_0001, 6);
      expect_wr(4'd1, 32'h0000_0000, 8);
      expect_wr(4'd1, 32'hFFFF_FFFF, 10);
      expect_wr(4'd3, 32'hFFFF_FFFF, 12);
      do_reset();
      run("wrap", 16, -1);

      // Logic ops, reloading r1 before each
      clear_imem();
      imem[0]  = 32'h0110_0000; imem[1]  = 32'hF0F0_F0F0;
      imem[2]  = 32'h0120_0000; imem[3]  = 32'h0FF0_0FF0;
      imem[5]  = 32'h2612_0000;
      imem[6]  = 32'h0110_0000; imem[7]  = 32'hF0F0_F0F0;
      imem[9]  = 32'h2B12_0000;
      imem[10] = 32'h0110_0000; imem[11] = 32'hF0F0_F0F0;
      imem[13] = 32'h2E12_0000;
      imem[14] = 32'h2C32_0000;
      imem[15] = 32'h0242_0000;
      expect_wr(4'd1, 32'hF0F0_F0F0, 4);
      expect_wr(4'd2, 32'h0FF0_0FF0, 6);
      expect_wr(4'd1, 32'h00F0_00F0, 8);
      expect_wr(4'd1, 32'hF0F0_F0F0, 10);
      expect_wr(4'd1, 32'hFFF0_FFF0, 12);
      expect_wr(4'd1, 32'hF0F0_F0F0, 14);
      expect_wr(4'd1, 32'hFF00_FF00, 16);
      expect_wr(4'd3, 32'hF00F_F00F, 17);
      expect_wr(4'd4, 32'h0FF0_0FF0, 18);
      do_reset();
      run("logic", 22, -1);

      // nop and unknown opcode: no writes, no stall
      clear_imem();
      imem[0] = 32'h0F00_0000; imem[1] = 32'hFF00_0000;
      do_reset();
      run("nop", 8, -1);

      // Asynchronous reset while the second ldi.l sits in OPERAND
      clear_imem();
      imem[0] = 32'h0110_0000; imem[1] = 32'h0000_0005;
      imem[3] = 32'h0120_0000; imem[4] = 32'h0000_0007;
      expect_wr(4'd1, 32'h5, 4);
      do_reset();
      run("pre-rst", 5, -1);
      #2 rst_i = 1'b1;
      #1;
      chk("async rst addr", imem_address_o, 32'h0);
      chk("async rst we", {31'd0, rf_write_enable_o}, 32'd0);
      chk("async rst stall", {31'd0, stall_o}, 32'd0);
      chk("async rst widx", {28'd0, rf_write_index_o}, 32'd0);
      chk("async rst wdata", rf_write_data_o, 32'd0);
      chk("async rst rden", {31'd0, rf_read_enable_o}, 32'd0);
      expect_wr(4'd1, 32'h5, 4);
      expect_wr(4'd2, 32'h7, 7);
      do_reset();
      run("post-rst", 10, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
